mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
Multi-cycle control sequencer for the RV32I datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and issues per-cycle write enables and memory requests, so the existing combinational decoder's RegWrite/MemWrite levels become single, correctly timed pulses. It also handles the instruction- and data-memory ready handshakes, traps illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for imem_ready/dmem_ready; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
op  in  7  opcode field from the instruction register; valid from the DECODE cycle onward
imem_ready  in  1  instruction memory has data this cycle
dmem_ready  in  1  data memory has completed the access this cycle
imem_req  out  1  instruction fetch request
ir_write  out  1  load instruction register (1-cycle pulse)
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write; only ever high together with dmem_req
reg_write  out  1  register file write (1-cycle pulse)
pc_write  out  1  commit next PC (1-cycle pulse)
retire  out  1  instruction completed; equals pc_write
trap  out  1  sticky trap indication
trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: rst is sampled on the rising edge and overrides every other event. It sets state=FETCH, the opcode class register, wait counter, trap, trap_cause and instret to 0.
- After reset release, imem_req is 1 (FETCH). All other outputs are 0.
- imem_req, ir_write, dmem_req, dmem_we, reg_write and pc_write are combinational from state, the latched class and the ready inputs. trap, trap_cause and instret are registered.
- Opcode classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other opcode is illegal.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1 and go to DECODE. Zero-wait memory gives a 1-cycle FETCH.
- DECODE:
  - Exactly 1 cycle. Register the class from op.
  - Illegal opcode -> TRAP with cause 01. Otherwise -> EXEC.
- EXEC: exactly 1 cycle.
  - BRANCH: pc_write=1, then FETCH.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE only.
  - On dmem_ready: STORE asserts pc_write=1 and goes to FETCH; LOAD goes to WB.
- WB: reg_write=1 and pc_write=1 for 1 cycle, then FETCH. This includes JAL/JALR link writes.
- Cycle counts with zero wait states: BRANCH 3; R/I-ALU/LUI/AUIPC/JAL/JALR/STORE 4; LOAD 5.
- pc_write is asserted exactly once per instruction, in its final cycle. It is never asserted for a trapped instruction.
- instret increments by 1 on every cycle with pc_write=1 and wraps from 2^CNT_W-1 to 0.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM while the relevant ready is low.
  - With MEM_TIMEOUT>0, a count reaching MEM_TIMEOUT while ready is still low -> TRAP next cycle, cause 10 (FETCH) or 11 (MEM).
  - Ready arriving in that same cycle wins: normal transition, no trap.
- TRAP:
  - trap=1 and trap_cause holds its value.
  - All request and enable outputs are 0.
  - Only rst exits TRAP.
- Ready inputs outside FETCH/MEM are ignored. op changes outside DECODE are ignored, because the class register holds.

Test Plan:
1. Reset, then op=0110011 (add) with imem_ready=1 and dmem_ready=1 tied high -> states 0,1,2,4; reg_write and pc_write high in cycle 4 only; instret=1.
2. op=0000011 (lw), dmem_ready low for 3 MEM cycles -> dmem_req high for 4 cycles with dmem_we=0; WB then pulses reg_write; total 8 cycles; instret increments by 1.
3. op=0100011 (sw) then op=1100011 (beq), zero wait -> sw: dmem_we=1 in MEM, reg_write never high, 4 cycles; beq: pc_write in EXEC, 3 cycles; instret=2.
4. op=0001011 (illegal) -> TRAP after DECODE, trap_cause=01; pc_write, imem_req and instret stay frozen for 20 cycles; rst returns to FETCH with trap=0.
5. MEM_TIMEOUT=4 with imem_ready held low -> TRAP, cause 10, after the count reaches 4. Repeat with imem_ready rising in the cycle the count hits 4 -> no trap, goes to DECODE.
6. CNT_W=4: 16 back-to-back addi (0010011) -> instret wraps to 0 on the 16th retire. Assert rst in the middle of a MEM wait -> next cycle state=0, dmem_req=0, instret=0.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping,
// memory handshakes, illegal-opcode and memory-timeout traps, retire count.
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             pc_write,
  output logic             retire,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int WW = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_IALU, C_LOAD, C_STORE,
    C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_op;
  logic [WW-1:0]    wcnt_q;
  logic             trap_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             to_hit;

  always_comb begin
    cls_op = C_NONE;
    case (op)
      7'b0110011: cls_op = C_R;
      7'b0010011: cls_op = C_IALU;
      7'b0000011: cls_op = C_LOAD;
      7'b0100011: cls_op = C_STORE;
      7'b1100011: cls_op = C_BRANCH;
      7'b1101111: cls_op = C_JAL;
      7'b1100111: cls_op = C_JALR;
      7'b0110111: cls_op = C_LUI;
      7'b0010111: cls_op = C_AUIPC;
      default:    cls_op = C_NONE;
    endcase
  end

  // the timeout fires on the cycle the count is observed at the limit
  assign to_hit = (MEM_TIMEOUT > 0) && (wcnt_q == WW'(MEM_TIMEOUT));

  always_comb begin
    state_d   = state_q;
    cause_d   = 2'b00;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (cls_op == C_NONE) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_BRANCH: begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ready) begin
          if (cls_q == C_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NONE;
      wcnt_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_op;
      if (state_d != state_q)
        wcnt_q <= '0;
      else if ((state_q == S_FETCH || state_q == S_MEM) && wcnt_q != '1)
        wcnt_q <= wcnt_q + WW'(1);
      if (state_d == S_TRAP && state_q != S_TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
      if (pc_write) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign retire     = pc_write;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized bench for mc_sequencer: per-instruction expected cycle
// sequences are built from class latencies and wait counts.
module tb_mc_sequencer;
  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0001011;

  logic clk = 1'b0;
  logic rst, imem_ready, dmem_ready;
  logic [6:0] op;
  logic imem_req, ir_write, dmem_req, dmem_we;
  logic reg_write, pc_write, retire, trap;
  logic [1:0] trap_cause;
  logic [2:0] state;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  mc_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_write(reg_write), .pc_write(pc_write),
    .retire(retire), .trap(trap), .trap_cause(trap_cause),
    .state(state), .instret(instret)
  );

  typedef struct {
    int st;
    bit imr, dmr;
    logic [6:0] op;
    bit imq, irw, dmq, dwe, rw, pw, tr;
    logic [1:0] cs;
  } cyc_t;

  cyc_t q[$];
  int nvec = 0;
  int nerr = 0;
  int m_instret = 0;

  logic [16:0] obs;
  assign obs = {state, imem_req, ir_write, dmem_req, dmem_we,
                reg_write, pc_write, retire, trap, trap_cause, instret};

  function automatic logic [16:0] expv(cyc_t c, int n);
    return {3'(c.st), c.imq, c.irw, c.dmq, c.dwe, c.rw,
            c.pw, c.pw, c.tr, c.cs, 4'(n)};
  endfunction

  function automatic cyc_t mk(int st);
    cyc_t c;
    c = '{default: 0};
    c.st = st;
    c.imr = 1'($urandom);
    c.dmr = 1'($urandom);
    c.op = 7'($urandom);
    return c;
  endfunction

  function automatic bit legal(logic [6:0] o);
    return o inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR,
                     7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  function automatic void add_trap(logic [1:0] cs, int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = mk(5);
      c.tr = 1'b1;
      c.cs = cs;
      q.push_back(c);
    end
  endfunction

  // expected cycles: fetch waits, decode, exec, mem waits, writeback
  function automatic void gen(logic [6:0] o, int fw, int mw, int ntrap);
    cyc_t c;
    bit st = (o == OP_ST);
    bit ls = (o == OP_LD) || st;
    q.delete();
    for (int i = 0; i <= fw && i <= TO; i++) begin
      c = mk(0);
      c.imq = 1'b1;
      c.imr = (i == fw);
      c.irw = (i == fw);
      q.push_back(c);
    end
    if (fw > TO) begin add_trap(2'b10, ntrap); return; end
    c = mk(1);
    c.op = o;
    q.push_back(c);
    if (!legal(o)) begin add_trap(2'b01, ntrap); return; end
    c = mk(2);
    c.pw = (o == OP_BR);
    q.push_back(c);
    if (o == OP_BR) return;
    if (ls) begin
      for (int i = 0; i <= mw && i <= TO; i++) begin
        c = mk(3);
        c.dmq = 1'b1;
        c.dwe = st;
        c.dmr = (i == mw);
        c.pw = st && (i == mw);
        q.push_back(c);
      end
      if (mw > TO) begin add_trap(2'b11, ntrap); return; end
      if (st) return;
    end
    c = mk(4);
    c.rw = 1'b1;
    c.pw = 1'b1;
    q.push_back(c);
  endfunction

  task automatic drive(cyc_t c);
    imem_ready = c.imr;
    dmem_ready = c.dmr;
    op = c.op;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    op = 7'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    m_instret = 0;
  endtask

  task automatic test_reset();
    cyc_t c;
    do_reset();
    c = mk(0);
    c.imq = 1'b1;
    c.imr = 1'b0;
    drive(c);
    nvec++;
    if (obs !== expv(c, 0)) begin
      nerr++;
      $display("FAIL reset: got %h want %h", obs, expv(c, 0));
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_alu();
    gen(OP_R, 0, 0, 0);
    foreach (q[i]) begin
      drive(q[i]);
      nvec++;
      if (obs !== expv(q[i], m_instret)) begin
        nerr++;
        $display("FAIL add c%0d: got %h want %h", i, obs, expv(q[i], m_instret));
      end
      if (q[i].pw) m_instret++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    gen(OP_LD, 0, 3, 0);
    foreach (q[i]) begin
      drive(q[i]);
      nvec++;
      if (obs !== expv(q[i], m_instret)) begin
        nerr++;
        $display("FAIL lw c%0d: got %h want %h", i, obs, expv(q[i], m_instret));
      end
      if (q[i].pw) m_instret++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_branch();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      gen(k == 0 ? OP_ST : OP_BR, 0, 0, 0);
      foreach (q[i]) begin
        drive(q[i]);
        nvec++;
        if (obs !== expv(q[i], m_instret)) begin
          nerr++;
          $display("FAIL sw_beq k%0d c%0d: got %h want %h", k, i, obs,
                   expv(q[i], m_instret));
        end
        if (q[i].pw) m_instret++;
        @(posedge clk); #1;
      end
    end
    if (m_instret != 2) begin
      nerr++;
      $display("FAIL sw_beq count: got %0d want 2", m_instret);
    end
  endtask

  task automatic test_traps();
    cyc_t c;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      gen(OP_I, 0, 0, 0);
      foreach (q[i]) begin
        drive(q[i]);
        if (q[i].pw) m_instret++;
        @(posedge clk); #1;
      end
      case (k)
        0: gen(OP_BAD, 0, 0, 20);
        1: gen(OP_R, TO + 1, 0, 6);
        default: gen(OP_LD, 0, TO + 1, 6);
      endcase
      foreach (q[i]) begin
        drive(q[i]);
        nvec++;
        if (obs !== expv(q[i], m_instret)) begin
          nerr++;
          $display("FAIL trap k%0d c%0d: got %h want %h", k, i, obs,
                   expv(q[i], m_instret));
        end
        if (q[i].pw) m_instret++;
        @(posedge clk); #1;
      end
      do_reset();
      c = mk(0);
      c.imq = 1'b1;
      c.imr = 1'b0;
      drive(c);
      nvec++;
      if (obs !== expv(c, 0)) begin
        nerr++;
        $display("FAIL trap_exit k%0d: got %h want %h", k, obs, expv(c, 0));
      end
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic test_ready_at_limit();
    for (int k = 0; k < 2; k++) begin
      gen(k == 0 ? OP_R : OP_ST, k == 0 ? TO : 0, TO, 0);
      foreach (q[i]) begin
        drive(q[i]);
        nvec++;
        if (obs !== expv(q[i], m_instret)) begin
          nerr++;
          $display("FAIL limit k%0d c%0d: got %h want %h", k, i, obs,
                   expv(q[i], m_instret));
        end
        if (q[i].pw) m_instret++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    for (int k = 0; k < 60; k++) begin
      gen(ops[$urandom_range(0, 8)], $urandom_range(0, TO),
          $urandom_range(0, TO), 0);
      foreach (q[i]) begin
        drive(q[i]);
        nvec++;
        if (obs !== expv(q[i], m_instret)) begin
          nerr++;
          $display("FAIL rand k%0d c%0d op%b: got %h want %h", k, i,
                   q[1].op, obs, expv(q[i], m_instret));
        end
        if (q[i].pw) m_instret++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      gen(OP_I, 0, 0, 0);
      foreach (q[i]) begin
        drive(q[i]);
        nvec++;
        if (obs !== expv(q[i], m_instret)) begin
          nerr++;
          $display("FAIL addi k%0d c%0d: got %h want %h", k, i, obs,
                   expv(q[i], m_instret));
        end
        if (q[i].pw) m_instret++;
        @(posedge clk); #1;
      end
    end
    imem_ready = 1'b0;
    @(negedge clk);
    nvec++;
    if (instret !== 4'd0 || state !== 3'd0) begin
      nerr++;
      $display("FAIL wrap: got instret %0d state %0d want 0 0", instret, state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mem();
    cyc_t c;
    do_reset();
    gen(OP_I, 0, 0, 0);
    foreach (q[i]) begin
      drive(q[i]);
      if (q[i].pw) m_instret++;
      @(posedge clk); #1;
    end
    gen(OP_LD, 0, TO + 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(q[i]);
      nvec++;
      if (obs !== expv(q[i], m_instret)) begin
        nerr++;
        $display("FAIL midmem c%0d: got %h want %h", i, obs,
                 expv(q[i], m_instret));
      end
      if (i == 4) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    m_instret = 0;
    c = mk(0);
    c.imq = 1'b1;
    c.imr = 1'b0;
    drive(c);
    nvec++;
    if (obs !== expv(c, 0)) begin
      nerr++;
      $display("FAIL midmem_rst: got %h want %h", obs, expv(c, 0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    op = '0;
    test_reset();
    test_alu();
    test_load_wait();
    test_store_branch();
    test_traps();
    test_ready_at_limit();
    test_random();
    test_back_to_back();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
